// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 register
// window. It emits one packed window per accepted pixel at rows/cols >= 2.
module conv_window_gen #(
    parameter int RESOLUTION      = 16,
    parameter int IMG_WIDTH       = 28,
    parameter int IMG_HEIGHT      = 28,
    parameter int WINDOW_ELEMENTS = 9
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic                                  in_sof,
    input  logic [RESOLUTION-1:0]                 in_pixel,
    output logic                                  win_valid,
    output logic [WINDOW_ELEMENTS*RESOLUTION-1:0] win_data,
    output logic                                  win_last,
    output logic                                  frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RH = $clog2(IMG_HEIGHT);

    logic [CW-1:0]         r_col;
    logic [RH-1:0]         r_row;
    logic [RESOLUTION-1:0] r_lb1 [IMG_WIDTH];
    logic [RESOLUTION-1:0] r_lb2 [IMG_WIDTH];
    logic [RESOLUTION-1:0] r_c2  [3];
    logic [RESOLUTION-1:0] r_c1  [3];
    logic                  r_win_valid;
    logic                  r_win_last;
    logic [WINDOW_ELEMENTS*RESOLUTION-1:0] r_win_data;

    logic [CW-1:0]         w_col;
    logic [RH-1:0]         w_row;
    logic [CW-1:0]         w_col_nxt;
    logic [RH-1:0]         w_row_nxt;
    logic                  w_col_end;
    logic                  w_row_end;
    logic                  w_fire;
    logic                  w_last;
    logic [RESOLUTION-1:0] w_new [3];
    logic [WINDOW_ELEMENTS*RESOLUTION-1:0] w_pack;

    // A start-of-frame pixel is forced to (0,0), overriding whatever the counters hold.
    always_comb begin
        w_col     = in_sof ? '0 : r_col;
        w_row     = in_sof ? '0 : r_row;
        w_col_end = (w_col == CW'(IMG_WIDTH - 1));
        w_row_end = (w_row == RH'(IMG_HEIGHT - 1));
        w_col_nxt = w_col_end ? '0 : w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col_end) begin
            w_row_nxt = w_row_end ? '0 : w_row + 1'b1;
        end
        w_fire    = in_valid && (w_row >= RH'(2)) && (w_col >= CW'(2));
        w_last    = in_valid && w_row_end && w_col_end;
    end

    always_comb begin
        w_new[0] = r_lb2[w_col];
        w_new[1] = r_lb1[w_col];
        w_new[2] = in_pixel;
        w_pack   = '0;
        for (int i = 0; i < 3; i++) begin
            w_pack[(WINDOW_ELEMENTS-1-3*i)*RESOLUTION +: RESOLUTION] = r_c2[i];
            w_pack[(WINDOW_ELEMENTS-2-3*i)*RESOLUTION +: RESOLUTION] = r_c1[i];
            w_pack[(WINDOW_ELEMENTS-3-3*i)*RESOLUTION +: RESOLUTION] = w_new[i];
        end
    end

    // Line buffers hold no reset: rows 0/1 are always written before a valid window reads them.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb2[w_col] <= r_lb1[w_col];
            r_lb1[w_col] <= in_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            r_win_data  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_c2[i] <= '0;
                r_c1[i] <= '0;
            end
        end else begin
            r_win_valid <= w_fire;
            r_win_last  <= w_last;
            if (in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                for (int i = 0; i < 3; i++) begin
                    r_c2[i] <= r_c1[i];
                    r_c1[i] <= w_new[i];
                end
            end
            if (w_fire) begin
                r_win_data <= w_pack;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign win_data   = r_win_data;
    assign win_last   = r_win_last;
    assign frame_done = r_win_last;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed 4x4 scenarios with hand-computed windows,
// plus one 28x28 random frame checked against a 2-D array model.
module tb_conv_window_gen;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         s_valid, s_sof;
  logic [15:0]  s_pix;
  logic         s_wv, s_wl, s_fd;
  logic [143:0] s_wd;

  logic         b_valid, b_sof;
  logic [15:0]  b_pix;
  logic         b_wv, b_wl, b_fd;
  logic [143:0] b_wd;

  int n_cmp = 0;
  int n_err = 0;
  int n_seen = 0;
  int n_fd = 0;
  logic prev_valid = 1'b0;
  logic [144:0] exp_q[$];
  logic [15:0] px [784];

  conv_window_gen #(.RESOLUTION(16), .IMG_WIDTH(4), .IMG_HEIGHT(4), .WINDOW_ELEMENTS(9)) dut_small (
    .clk(clk), .rst(rst_n), .in_valid(s_valid), .in_sof(s_sof), .in_pixel(s_pix),
    .win_valid(s_wv), .win_data(s_wd), .win_last(s_wl), .frame_done(s_fd)
  );

  conv_window_gen dut_big (
    .clk(clk), .rst(rst_n), .in_valid(b_valid), .in_sof(b_sof), .in_pixel(b_pix),
    .win_valid(b_wv), .win_data(b_wd), .win_last(b_wl), .frame_done(b_fd)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] pack9(input int a, b, c, d, e, f, g, h, i);
    return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h), 16'(i)};
  endfunction

  // Windows of a 4x4 frame holding base+0..base+15, in emission order.
  task automatic expect_frame(input int b);
    exp_q.push_back({1'b0, pack9(b+0, b+1, b+2, b+4, b+5, b+6, b+8, b+9, b+10)});
    exp_q.push_back({1'b0, pack9(b+1, b+2, b+3, b+5, b+6, b+7, b+9, b+10, b+11)});
    exp_q.push_back({1'b0, pack9(b+4, b+5, b+6, b+8, b+9, b+10, b+12, b+13, b+14)});
    exp_q.push_back({1'b1, pack9(b+5, b+6, b+7, b+9, b+10, b+11, b+13, b+14, b+15)});
  endtask

  // driver tasks
  task automatic send(input logic sof, input int pix, input bit gap);
    @(negedge clk);
    s_valid = 1'b1;
    s_sof   = sof;
    s_pix   = 16'(pix);
    if (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
    end
  endtask

  task automatic end_scn(input string tag, input int exp_wins, input int exp_fd);
    idle(3);
    check({tag, "_win_count"}, 160'(n_seen), 160'(exp_wins));
    check({tag, "_frame_done_count"}, 160'(n_fd), 160'(exp_fd));
    check({tag, "_exp_left"}, 160'(exp_q.size()), 160'(0));
    exp_q.delete();
    n_seen = 0;
    n_fd   = 0;
  endtask

  // scoreboard for the 4x4 instance
  always @(posedge clk) prev_valid = s_valid;

  always @(negedge clk) begin
    logic [144:0] e;
    if (rst_n) begin
      if (!prev_valid) check("gap_quiet", 160'({s_wv, s_wl, s_fd}), 160'(0));
      if (s_fd) n_fd++;
      if (s_wv) begin
        n_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_win", 160'(s_wd), 160'(0));
        end else begin
          e = exp_q.pop_front();
          check("win_data", 160'(s_wd), 160'(e[143:0]));
          check("win_last", 160'(s_wl), 160'(e[144]));
        end
      end
    end
  end

  initial begin
    logic [143:0] e;
    int r, c, big_wins;
    rst_n = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_pix = '0;
    b_valid = 1'b0; b_sof = 1'b0; b_pix = '0;
    repeat (3) @(negedge clk);
    check("reset_small", 160'({s_wv, s_wl, s_fd, s_wd}), 160'(0));
    check("reset_big", 160'({b_wv, b_wl, b_fd, b_wd}), 160'(0));
    rst_n = 1'b1;
    idle(2);

    // continuous 4x4 frame
    expect_frame(0);
    for (int k = 0; k < 16; k++) send(k == 0, k, 1'b0);
    end_scn("cont", 4, 1);

    // same frame with a gap after every pixel
    expect_frame(0);
    for (int k = 0; k < 16; k++) send(k == 0, k, 1'b1);
    end_scn("gaps", 4, 1);

    // two back-to-back frames, second without in_sof
    expect_frame(0);
    expect_frame(100);
    for (int k = 0; k < 32; k++) send(k == 0, (k < 16) ? k : 100 + k - 16, 1'b0);
    end_scn("b2b", 8, 2);

    // abort at pixel 6 by a new start-of-frame
    expect_frame(200);
    for (int k = 0; k < 6; k++) send(k == 0, k, 1'b0);
    for (int k = 0; k < 16; k++) send(k == 0, 200 + k, 1'b0);
    end_scn("abort", 4, 1);

    // start-of-frame landing on the last-pixel position
    exp_q.push_back({1'b0, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10)});
    exp_q.push_back({1'b0, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11)});
    exp_q.push_back({1'b0, pack9(4, 5, 6, 8, 9, 10, 12, 13, 14)});
    expect_frame(300);
    for (int k = 0; k < 15; k++) send(k == 0, k, 1'b0);
    for (int k = 0; k < 16; k++) send(k == 0, 300 + k, 1'b0);
    end_scn("sof_last", 7, 1);

    // reset mid-frame after pixel 9, then a frame without in_sof
    for (int k = 0; k < 10; k++) send(k == 0, k, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("midrst_outputs_a", 160'({s_wv, s_wl, s_fd, s_wd}), 160'(0));
    @(negedge clk);
    #1 check("midrst_outputs_b", 160'({s_wv, s_wl, s_fd, s_wd}), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    expect_frame(0);
    for (int k = 0; k < 16; k++) send(1'b0, k, 1'b0);
    end_scn("midrst", 4, 1);

    // 28x28 random frame against the array model
    for (int k = 0; k < 784; k++) px[k] = 16'($urandom_range(0, 65535));
    big_wins = 0;
    for (int k = 0; k <= 784; k++) begin
      @(negedge clk);
      if (k > 0) begin
        r = (k - 1) / 28;
        c = (k - 1) % 28;
        if (r >= 2 && c >= 2) begin
          e = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              e[(8 - (3*i + j))*16 +: 16] = px[(r - 2 + i)*28 + (c - 2 + j)];
          big_wins++;
          check("big_valid", 160'(b_wv), 160'(1));
          check("big_data", 160'(b_wd), 160'(e));
          check("big_last", 160'({b_wl, b_fd}), 160'({2{k == 784}}));
        end else begin
          check("big_idle", 160'({b_wv, b_wl, b_fd}), 160'(0));
        end
      end
      if (k < 784) begin
        b_valid = 1'b1;
        b_sof   = (k == 0);
        b_pix   = px[k];
      end else begin
        b_valid = 1'b0;
        b_sof   = 1'b0;
      end
    end
    @(negedge clk);
    check("big_quiet_after", 160'({b_wv, b_wl, b_fd}), 160'(0));
    check("big_win_count", 160'(big_wins), 160'(676));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
